lc4_imem_responder: RTL and testbench

Instruction-memory responder for the LC4 fetch path: the memory-side end of the cache-to-memory interface. It accepts a read address from the instruction cache every cycle, reads a word-addressed backing array and returns the word exactly LATENCY cycles later with the originating address attached. This matches the fixed fetch latency the cache expects on a miss. A separate load port lets the bench or boot logic write program words into the array.

---
 rtl/lc4_mem_pkg.sv | 14 +
 rtl/lc4_imem_responder_if.sv | 25 ++
 rtl/lc4_delay_pipe.sv | 31 +++
 rtl/lc4_imem_responder.sv | 85 ++++++++
 tb/tb_lc4_imem_responder.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/lc4_mem_pkg.sv
// Shared widths and the response payload type for the LC4 instruction-memory path.
package lc4_mem_pkg;

    localparam int unsigned ADDR_W          = 16;
    localparam int unsigned DATA_W          = 16;
    localparam int unsigned LATENCY_DEFAULT = 8;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mem_rsp_t;

endpackage

// File: rtl/lc4_imem_responder_if.sv
// Cache-to-memory fetch bus: request, response, program-load port and status.
interface lc4_imem_responder_if;

    logic                             req_valid;
    logic [lc4_mem_pkg::ADDR_W-1:0]   req_addr;
    logic                             rsp_valid;
    logic [lc4_mem_pkg::ADDR_W-1:0]   rsp_addr;
    logic [lc4_mem_pkg::DATA_W-1:0]   rsp_data;
    logic                             ld_en;
    logic [lc4_mem_pkg::ADDR_W-1:0]   ld_addr;
    logic [lc4_mem_pkg::DATA_W-1:0]   ld_data;
    logic [4:0]                       inflight;
    logic [15:0]                      req_cnt;

    modport master (
        output req_valid, req_addr, ld_en, ld_addr, ld_data,
        input  rsp_valid, rsp_addr, rsp_data, inflight, req_cnt
    );

    modport slave (
        input  req_valid, req_addr, ld_en, ld_addr, ld_data,
        output rsp_valid, rsp_addr, rsp_data, inflight, req_cnt
    );

endinterface

// File: rtl/lc4_delay_pipe.sv
// Fixed-depth shift pipeline of response payloads; advances only when en is high.
module lc4_delay_pipe
    import lc4_mem_pkg::*;
#(
    parameter int unsigned Depth = LATENCY_DEFAULT
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     en,
    input  mem_rsp_t in_rsp,
    output mem_rsp_t out_rsp
);

    mem_rsp_t stage_q [Depth];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(Depth); i++) begin
                stage_q[i] <= '0;
            end
        end else if (en) begin
            stage_q[0] <= in_rsp;
            for (int i = 1; i < int'(Depth); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign out_rsp = stage_q[Depth-1];

endmodule

// File: rtl/lc4_imem_responder.sv
// Memory-side responder for LC4 instruction fetch: fixed-latency reads from a loadable array.
module lc4_imem_responder
    import lc4_mem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 16,
    parameter int unsigned LATENCY    = LATENCY_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 gwe,
    lc4_imem_responder_if.slave  bus
);

    localparam int unsigned Words = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0]     mem [Words];
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [DEPTH_LOG2-1:0] ld_idx;
    logic                  accept;
    logic                  load;
    logic                  leave;
    mem_rsp_t              pipe_in;
    mem_rsp_t              pipe_out;
    logic [4:0]            inflight_q, inflight_d;
    logic [15:0]           req_cnt_q, req_cnt_d;

    assign rd_idx = bus.req_addr[DEPTH_LOG2-1:0];
    assign ld_idx = bus.ld_addr[DEPTH_LOG2-1:0];
    assign accept = gwe & bus.req_valid;
    assign load   = gwe & bus.ld_en;

    // Backing array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (load) begin
            mem[ld_idx] <= bus.ld_data;
        end
    end

    // Write-first bypass when a load and a read hit the same word in one cycle.
    always_comb begin
        pipe_in = '0;
        if (accept) begin
            pipe_in.valid = 1'b1;
            pipe_in.addr  = bus.req_addr;
            pipe_in.data  = (load && (ld_idx == rd_idx)) ? bus.ld_data : mem[rd_idx];
        end
    end

    lc4_delay_pipe #(
        .Depth (LATENCY)
    ) u_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (gwe),
        .in_rsp  (pipe_in),
        .out_rsp (pipe_out)
    );

    assign leave = gwe & pipe_out.valid;

    always_comb begin
        inflight_d = inflight_q + {4'b0, accept} - {4'b0, leave};
        req_cnt_d  = req_cnt_q;
        if (accept && (req_cnt_q != 16'hFFFF)) begin
            req_cnt_d = req_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
            req_cnt_q  <= '0;
        end else begin
            inflight_q <= inflight_d;
            req_cnt_q  <= req_cnt_d;
        end
    end

    assign bus.rsp_valid = pipe_out.valid;
    assign bus.rsp_addr  = pipe_out.addr;
    assign bus.rsp_data  = pipe_out.data;
    assign bus.inflight  = inflight_q;
    assign bus.req_cnt   = req_cnt_q;

endmodule

// File: tb/tb_lc4_imem_responder.sv
// Randomized scoreboard bench for lc4_imem_responder against a word-array reference model.
module tb_lc4_imem_responder;
    import lc4_mem_pkg::*;

    localparam int unsigned LAT = LATENCY_DEFAULT;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic gwe = 1'b0;

    lc4_imem_responder_if bus();

    lc4_imem_responder #(
        .DEPTH_LOG2 (16),
        .LATENCY    (LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .gwe   (gwe),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          gcount = 0;      // rising edges seen with gwe high
    int          acc = 0;         // accepted requests since reset
    int          resp_seen = 0;
    int          peak = 0;
    exp_t        sbq[$];
    logic [15:0] mem_m[int];
    int          loaded[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then apply the reference model at the edge.
    task automatic cycle(input bit v, input logic [15:0] a, input bit g, input bit l,
                         input logic [15:0] la, input logic [15:0] ldv);
        exp_t e;
        bus.req_valid = v;
        bus.req_addr  = v ? a : 16'h0;
        gwe           = g;
        bus.ld_en     = l;
        bus.ld_addr   = la;
        bus.ld_data   = ldv;
        @(posedge clk);
        if (rst_n && g) begin
            gcount++;
            if (v) begin
                e.addr = a;
                e.data = (l && la == a) ? ldv : mem_m[int'(a)];
                e.due  = gcount + int'(LAT) - 1;
                sbq.push_back(e);
                acc++;
            end
            if (l) mem_m[int'(la)] = ldv;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 16'h0);
    endtask

    // Monitor: compares presented outputs against the head of the scoreboard.
    always @(negedge clk) begin
        bit exp_v;
        chk("inflight", {27'b0, bus.inflight}, sbq.size());
        chk("req_cnt", {16'b0, bus.req_cnt}, (acc > 65535) ? 65535 : acc);
        if (int'(bus.inflight) > peak) peak = int'(bus.inflight);
        exp_v = (sbq.size() > 0) && (sbq[0].due == gcount);
        chk("rsp_valid", {31'b0, bus.rsp_valid}, {31'b0, exp_v});
        if (bus.rsp_valid) resp_seen++;
        if (exp_v) begin
            chk("rsp_addr", {16'b0, bus.rsp_addr}, {16'b0, sbq[0].addr});
            chk("rsp_data", {16'b0, bus.rsp_data}, {16'b0, sbq[0].data});
            if (gwe) void'(sbq.pop_front());
        end else begin
            chk("idle_rsp_addr", {16'b0, bus.rsp_addr}, 32'h0);
            chk("idle_rsp_data", {16'b0, bus.rsp_data}, 32'h0);
        end
    end

    initial begin
        int          base;
        bit          v, g, l;
        logic [15:0] a, la, d;

        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.ld_en     = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_data   = '0;
        #1 rst_n = 1'b0;
        idle(3);
        chk("reset_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
        chk("reset_rsp_addr", {16'b0, bus.rsp_addr}, 32'h0);
        chk("reset_rsp_data", {16'b0, bus.rsp_data}, 32'h0);
        chk("reset_inflight", {27'b0, bus.inflight}, 32'h0);
        chk("reset_req_cnt", {16'b0, bus.req_cnt}, 32'h0);
        rst_n = 1'b1;

        // Program load
        for (int i = 0; i < 32; i++) begin
            cycle(1'b0, 16'h0, 1'b1, 1'b1, 16'(i), 16'($urandom));
            loaded.push_back(i);
        end
        cycle(1'b0, 16'h0, 1'b1, 1'b1, 16'h0040, 16'h1234);
        loaded.push_back(16'h0040);
        cycle(1'b0, 16'h0, 1'b1, 1'b1, 16'h0007, 16'hAAAA);

        // Single read
        cycle(1'b1, 16'h0040, 1'b1, 1'b0, 16'h0, 16'h0);
        chk("single_inflight_up", {27'b0, bus.inflight}, 32'h1);
        idle(int'(LAT) + 2);
        chk("single_inflight_down", {27'b0, bus.inflight}, 32'h0);

        // Streaming
        peak = 0;
        for (int i = 0; i < 20; i++) cycle(1'b1, 16'(i), 1'b1, 1'b0, 16'h0, 16'h0);
        idle(int'(LAT) + 2);
        chk("stream_peak", peak, LAT);
        chk("stream_req_cnt", {16'b0, bus.req_cnt}, 32'd21);

        // Stall with 4 requests in flight
        for (int i = 20; i < 24; i++) cycle(1'b1, 16'(i), 1'b1, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        idle(int'(LAT) + 4);

        // Load/read collision
        cycle(1'b1, 16'h0007, 1'b1, 1'b1, 16'h0007, 16'h5555);
        idle(int'(LAT) + 2);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            v  = ($urandom % 10) < 7;
            a  = 16'(loaded[$urandom % loaded.size()]);
            g  = ($urandom % 10) < 8;
            l  = ($urandom % 10) < 2;
            la = (($urandom % 4) == 0) ? a : 16'($urandom_range(0, 65535));
            d  = 16'($urandom);
            cycle(v, a, g, l, la, d);
            if (g && l) loaded.push_back(int'(la));
        end
        idle(int'(LAT) + 6);

        // Reset while requests are in flight
        base = resp_seen;
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'(i + 8), 1'b1, 1'b0, 16'h0, 16'h0);
        for (int k = 0; k < 40 && resp_seen < base + 3; k++) idle(1);
        chk("rst_third_rsp_seen", resp_seen - base, 3);
        rst_n = 1'b0;
        sbq.delete();
        acc = 0;
        #1;
        chk("rst_inflight_now", {27'b0, bus.inflight}, 32'h0);
        chk("rst_rsp_valid_now", {31'b0, bus.rsp_valid}, 32'h0);
        chk("rst_req_cnt_now", {16'b0, bus.req_cnt}, 32'h0);
        idle(1);
        rst_n = 1'b1;
        idle(20);
        chk("rst_no_late_rsp", resp_seen - base, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
